mc_ctrl_fsm: RTL and testbench

- Multicycle control unit that sequences the MIPS datapath: PC, IR, ALU, data memory and general-purpose register file (gpr).
- One instruction executes in 3–5 cycles.
- Takes opcode, funct and ALU flags from the datapath. Drives all write strobes and mux selects.
- Reports overflow and illegal-instruction events so the datapath can update the status register ($30).

---
 rtl/mc_ctrl_fsm.sv | 175 +++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control unit; sequences PC, IR, ALU, data memory and gpr.
// Latency: 3-5 cycles per instruction; outputs are combinational from state/op/funct (+zero/OF).
// Backpressure: none; the FSM advances every cycle. rst forces every strobe and select to 0.
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   op, funct       - IR[31:26], IR[5:0]; stable from DECODE onward
//   zero, OF        - registered ALU flags (zero used in BRANCH, OF in ALUWB)
//   pc_wr..mem_wr   - write strobes; reg_dst, wd_sel, alu_srcb, ext_op, alu_op, npc_op - selects
//   ovf_set, illegal- one-cycle event pulses for the status register; state - debug view
module mc_ctrl_fsm #(
  parameter int OVF_TRAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       OF,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       mem_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_srcb,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic [1:0] npc_op,
  output logic       ovf_set,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXE    = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ   = 6'h04, OP_ADDI = 6'h08, OP_ORI = 6'h0D,
                         OP_LUI   = 6'h0F, OP_LW  = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_ADDU = 6'h21,
                         FN_SUBU = 6'h23, FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_SLT = 3'd3;

  state_t state_q, state_d;

  logic is_r, is_jr, is_r_alu, is_add_ovf, trap;

  assign is_r       = (op == OP_RTYPE);
  assign is_jr      = is_r && (funct == FN_JR);
  assign is_r_alu   = is_r && (funct == FN_ADD || funct == FN_ADDU ||
                                funct == FN_SUBU || funct == FN_SLT);
  // Only the signed adds trap; addu and the logical ops ignore OF.
  assign is_add_ovf = (is_r && funct == FN_ADD) || (op == OP_ADDI);
  assign trap       = (OVF_TRAP != 0) && is_add_ovf && OF;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d  = S_FETCH;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    reg_wr   = 1'b0;
    mem_wr   = 1'b0;
    reg_dst  = 2'd0;
    wd_sel   = 2'd0;
    alu_srcb = 1'b0;
    ext_op   = 2'd0;
    alu_op   = ALU_ADD;
    npc_op   = 2'd0;
    ovf_set  = 1'b0;
    illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        pc_wr   = 1'b1;
        ir_wr   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW)                          state_d = S_MEMADR;
        else if (is_r_alu || op == OP_ORI || op == OP_LUI ||
                 op == OP_ADDI)                                  state_d = S_EXE;
        else if (op == OP_BEQ)                                   state_d = S_BRANCH;
        else if (op == OP_J || op == OP_JAL || is_jr)            state_d = S_JUMP;
        else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_srcb = 1'b1;
        ext_op   = 2'd1;
        alu_op   = ALU_ADD;
        state_d  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: state_d = S_MEMWB;
      S_MEMWB: begin
        reg_wr = 1'b1;
        wd_sel = 2'd1;
      end
      S_MEMWR: mem_wr = 1'b1;
      S_EXE: begin
        state_d = S_ALUWB;
        if (is_r) begin
          case (funct)
            FN_SUBU: alu_op = ALU_SUB;
            FN_SLT:  alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
          endcase
        end else begin
          alu_srcb = 1'b1;
          case (op)
            OP_ORI:  begin ext_op = 2'd0; alu_op = ALU_OR;  end
            OP_LUI:  begin ext_op = 2'd2; alu_op = ALU_OR;  end
            default: begin ext_op = 2'd1; alu_op = ALU_ADD; end
          endcase
        end
      end
      S_ALUWB: begin
        reg_dst = is_r ? 2'd1 : 2'd0;
        reg_wr  = ~trap;
        ovf_set = trap;
      end
      S_BRANCH: begin
        alu_op = ALU_SUB;
        npc_op = 2'd1;
        pc_wr  = zero;
      end
      S_JUMP: begin
        pc_wr  = 1'b1;
        npc_op = is_jr ? 2'd3 : 2'd2;
        if (op == OP_JAL) begin
          // PC already holds old PC+4 here, which is the link address.
          reg_wr  = 1'b1;
          reg_dst = 2'd2;
          wd_sel  = 2'd2;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Reset overrides everything so an aborted instruction never writes.
    if (rst) begin
      pc_wr    = 1'b0;
      ir_wr    = 1'b0;
      reg_wr   = 1'b0;
      mem_wr   = 1'b0;
      reg_dst  = 2'd0;
      wd_sel   = 2'd0;
      alu_srcb = 1'b0;
      ext_op   = 2'd0;
      alu_op   = ALU_ADD;
      npc_op   = 2'd0;
      ovf_set  = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven check of mc_ctrl_fsm, one row per clock cycle.
// Latency: inputs driven on falling edge, outputs compared 1 time unit later.
// Backpressure: not applicable.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero, OF;
  logic       pc_wr, ir_wr, reg_wr, mem_wr, alu_srcb, ovf_set, illegal;
  logic [1:0] reg_dst, wd_sel, ext_op, npc_op;
  logic [2:0] alu_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.OVF_TRAP(1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .OF(OF),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr), .mem_wr(mem_wr),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_srcb(alu_srcb), .ext_op(ext_op),
    .alu_op(alu_op), .npc_op(npc_op), .ovf_set(ovf_set), .illegal(illegal),
    .state(state)
  );

  typedef struct {
    logic       rst;
    logic [5:0] op, funct;
    logic       zero, of;
    logic [21:0] exp;   // {state,pc,ir,rw,mw,reg_dst,wd_sel,srcb,ext,alu_op,npc,ovf,ill}
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   passed = 0;

  function automatic logic [21:0] pack_exp(
    input logic [3:0] st, input logic pc, input logic ir, input logic rw, input logic mw,
    input logic [1:0] rd, input logic [1:0] wd, input logic sb, input logic [1:0] ex,
    input logic [2:0] ao, input logic [1:0] np, input logic ov, input logic il);
    return {st, pc, ir, rw, mw, rd, wd, sb, ex, ao, np, ov, il};
  endfunction

  task automatic row(input string name, input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic of, input logic [21:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.of = of; v.exp = e; v.name = name;
    vecs.push_back(v);
  endtask

  function automatic logic [21:0] actual();
    return {state, pc_wr, ir_wr, reg_wr, mem_wr, reg_dst, wd_sel, alu_srcb,
            ext_op, alu_op, npc_op, ovf_set, illegal};
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %06h expected %06h", name, act, exp);
  endtask

  // Shorthands for common expected rows.
  function automatic logic [21:0] e_fetch();
    return pack_exp(4'd0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0, 0);
  endfunction
  function automatic logic [21:0] e_idle(input logic [3:0] st);
    return pack_exp(st, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0, 0);
  endfunction

  initial begin
    // lw: 0,1,2,3,4
    row("lw_fetch",  0, 6'h23, 6'h00, 0, 0, e_fetch());
    row("lw_dec",    0, 6'h23, 6'h00, 0, 0, e_idle(4'd1));
    row("lw_madr",   0, 6'h23, 6'h00, 0, 0, pack_exp(4'd2, 0,0,0,0, 2'd0,2'd0, 1, 2'd1, 3'd0, 2'd0, 0,0));
    row("lw_mrd",    0, 6'h23, 6'h00, 0, 0, e_idle(4'd3));
    row("lw_mwb",    0, 6'h23, 6'h00, 0, 0, pack_exp(4'd4, 0,0,1,0, 2'd0,2'd1, 0, 2'd0, 3'd0, 2'd0, 0,0));
    // subu
    row("subu_fetch",0, 6'h00, 6'h23, 0, 0, e_fetch());
    row("subu_dec",  0, 6'h00, 6'h23, 0, 0, e_idle(4'd1));
    row("subu_exe",  0, 6'h00, 6'h23, 0, 0, pack_exp(4'd6, 0,0,0,0, 2'd0,2'd0, 0, 2'd0, 3'd1, 2'd0, 0,0));
    row("subu_wb",   0, 6'h00, 6'h23, 0, 0, pack_exp(4'd7, 0,0,1,0, 2'd1,2'd0, 0, 2'd0, 3'd0, 2'd0, 0,0));
    // addi with overflow: trapped
    row("addio_fetch",0, 6'h08, 6'h00, 0, 1, e_fetch());
    row("addio_dec", 0, 6'h08, 6'h00, 0, 1, e_idle(4'd1));
    row("addio_exe", 0, 6'h08, 6'h00, 0, 1, pack_exp(4'd6, 0,0,0,0, 2'd0,2'd0, 1, 2'd1, 3'd0, 2'd0, 0,0));
    row("addio_wb",  0, 6'h08, 6'h00, 0, 1, pack_exp(4'd7, 0,0,0,0, 2'd0,2'd0, 0, 2'd0, 3'd0, 2'd0, 1,0));
    // addi without overflow (also shows ovf_set dropped after one cycle)
    row("addi_fetch",0, 6'h08, 6'h00, 0, 0, e_fetch());
    row("addi_dec",  0, 6'h08, 6'h00, 0, 0, e_idle(4'd1));
    row("addi_exe",  0, 6'h08, 6'h00, 0, 0, pack_exp(4'd6, 0,0,0,0, 2'd0,2'd0, 1, 2'd1, 3'd0, 2'd0, 0,0));
    row("addi_wb",   0, 6'h08, 6'h00, 0, 0, pack_exp(4'd7, 0,0,1,0, 2'd0,2'd0, 0, 2'd0, 3'd0, 2'd0, 0,0));
    // add (R) with OF traps; addu with OF does not
    row("add_fetch", 0, 6'h00, 6'h20, 0, 1, e_fetch());
    row("add_dec",   0, 6'h00, 6'h20, 0, 1, e_idle(4'd1));
    row("add_exe",   0, 6'h00, 6'h20, 0, 1, pack_exp(4'd6, 0,0,0,0, 2'd0,2'd0, 0, 2'd0, 3'd0, 2'd0, 0,0));
    row("add_wb",    0, 6'h00, 6'h20, 0, 1, pack_exp(4'd7, 0,0,0,0, 2'd1,2'd0, 0, 2'd0, 3'd0, 2'd0, 1,0));
    row("addu_fetch",0, 6'h00, 6'h21, 0, 1, e_fetch());
    row("addu_dec",  0, 6'h00, 6'h21, 0, 1, e_idle(4'd1));
    row("addu_exe",  0, 6'h00, 6'h21, 0, 1, pack_exp(4'd6, 0,0,0,0, 2'd0,2'd0, 0, 2'd0, 3'd0, 2'd0, 0,0));
    row("addu_wb",   0, 6'h00, 6'h21, 0, 1, pack_exp(4'd7, 0,0,1,0, 2'd1,2'd0, 0, 2'd0, 3'd0, 2'd0, 0,0));
    // slt, ori, lui (lui with OF=1 must still write)
    row("slt_fetch", 0, 6'h00, 6'h2A, 0, 0, e_fetch());
    row("slt_dec",   0, 6'h00, 6'h2A, 0, 0, e_idle(4'd1));
    row("slt_exe",   0, 6'h00, 6'h2A, 0, 0, pack_exp(4'd6, 0,0,0,0, 2'd0,2'd0, 0, 2'd0, 3'd3, 2'd0, 0,0));
    row("slt_wb",    0, 6'h00, 6'h2A, 0, 0, pack_exp(4'd7, 0,0,1,0, 2'd1,2'd0, 0, 2'd0, 3'd0, 2'd0, 0,0));
    row("ori_fetch", 0, 6'h0D, 6'h00, 0, 0, e_fetch());
    row("ori_dec",   0, 6'h0D, 6'h00, 0, 0, e_idle(4'd1));
    row("ori_exe",   0, 6'h0D, 6'h00, 0, 0, pack_exp(4'd6, 0,0,0,0, 2'd0,2'd0, 1, 2'd0, 3'd2, 2'd0, 0,0));
    row("ori_wb",    0, 6'h0D, 6'h00, 0, 0, pack_exp(4'd7, 0,0,1,0, 2'd0,2'd0, 0, 2'd0, 3'd0, 2'd0, 0,0));
    row("lui_fetch", 0, 6'h0F, 6'h00, 0, 1, e_fetch());
    row("lui_dec",   0, 6'h0F, 6'h00, 0, 1, e_idle(4'd1));
    row("lui_exe",   0, 6'h0F, 6'h00, 0, 1, pack_exp(4'd6, 0,0,0,0, 2'd0,2'd0, 1, 2'd2, 3'd2, 2'd0, 0,0));
    row("lui_wb",    0, 6'h0F, 6'h00, 0, 1, pack_exp(4'd7, 0,0,1,0, 2'd0,2'd0, 0, 2'd0, 3'd0, 2'd0, 0,0));
    // beq taken / not taken
    row("beqt_fetch",0, 6'h04, 6'h00, 1, 0, e_fetch());
    row("beqt_dec",  0, 6'h04, 6'h00, 1, 0, e_idle(4'd1));
    row("beqt_br",   0, 6'h04, 6'h00, 1, 0, pack_exp(4'd8, 1,0,0,0, 2'd0,2'd0, 0, 2'd0, 3'd1, 2'd1, 0,0));
    row("beqn_fetch",0, 6'h04, 6'h00, 0, 0, e_fetch());
    row("beqn_dec",  0, 6'h04, 6'h00, 0, 0, e_idle(4'd1));
    row("beqn_br",   0, 6'h04, 6'h00, 0, 0, pack_exp(4'd8, 0,0,0,0, 2'd0,2'd0, 0, 2'd0, 3'd1, 2'd1, 0,0));
    // jal, j, jr
    row("jal_fetch", 0, 6'h03, 6'h00, 0, 0, e_fetch());
    row("jal_dec",   0, 6'h03, 6'h00, 0, 0, e_idle(4'd1));
    row("jal_jump",  0, 6'h03, 6'h00, 0, 0, pack_exp(4'd9, 1,0,1,0, 2'd2,2'd2, 0, 2'd0, 3'd0, 2'd2, 0,0));
    row("j_fetch",   0, 6'h02, 6'h00, 0, 0, e_fetch());
    row("j_dec",     0, 6'h02, 6'h00, 0, 0, e_idle(4'd1));
    row("j_jump",    0, 6'h02, 6'h00, 0, 0, pack_exp(4'd9, 1,0,0,0, 2'd0,2'd0, 0, 2'd0, 3'd0, 2'd2, 0,0));
    row("jr_fetch",  0, 6'h00, 6'h08, 0, 0, e_fetch());
    row("jr_dec",    0, 6'h00, 6'h08, 0, 0, e_idle(4'd1));
    row("jr_jump",   0, 6'h00, 6'h08, 0, 0, pack_exp(4'd9, 1,0,0,0, 2'd0,2'd0, 0, 2'd0, 3'd0, 2'd3, 0,0));
    // sw
    row("sw_fetch",  0, 6'h2B, 6'h00, 0, 0, e_fetch());
    row("sw_dec",    0, 6'h2B, 6'h00, 0, 0, e_idle(4'd1));
    row("sw_madr",   0, 6'h2B, 6'h00, 0, 0, pack_exp(4'd2, 0,0,0,0, 2'd0,2'd0, 1, 2'd1, 3'd0, 2'd0, 0,0));
    row("sw_mwr",    0, 6'h2B, 6'h00, 0, 0, pack_exp(4'd5, 0,0,0,1, 2'd0,2'd0, 0, 2'd0, 3'd0, 2'd0, 0,0));
    // illegal opcode and illegal R-type funct
    row("ill_fetch", 0, 6'h3F, 6'h00, 0, 0, e_fetch());
    row("ill_dec",   0, 6'h3F, 6'h00, 0, 0, pack_exp(4'd1, 0,0,0,0, 2'd0,2'd0, 0, 2'd0, 3'd0, 2'd0, 0,1));
    row("illf_fetch",0, 6'h00, 6'h3F, 0, 0, e_fetch());
    row("illf_dec",  0, 6'h00, 6'h3F, 0, 0, pack_exp(4'd1, 0,0,0,0, 2'd0,2'd0, 0, 2'd0, 3'd0, 2'd0, 0,1));
    // sw aborted by rst in MEMWR
    row("swr_fetch", 0, 6'h2B, 6'h00, 0, 0, e_fetch());
    row("swr_dec",   0, 6'h2B, 6'h00, 0, 0, e_idle(4'd1));
    row("swr_madr",  0, 6'h2B, 6'h00, 0, 0, pack_exp(4'd2, 0,0,0,0, 2'd0,2'd0, 1, 2'd1, 3'd0, 2'd0, 0,0));
    row("swr_mwr_rst",1, 6'h2B, 6'h00, 0, 0, e_idle(4'd5));
    row("swr_after", 1, 6'h2B, 6'h00, 0, 0, e_idle(4'd0));
    row("swr_resume",0, 6'h2B, 6'h00, 0, 0, e_fetch());
    row("swr_dec2",  0, 6'h2B, 6'h00, 0, 0, e_idle(4'd1));

    // Reset for two cycles with op=lw pending: no strobe or select may be active.
    rst = 1'b1; op = 6'h23; funct = 6'h00; zero = 1'b0; OF = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("rst_outputs", actual() & 22'h03FFFF, 22'h000000);
    end
    check("rst_state", {18'd0, state}, 22'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct;
      zero = vecs[i].zero; OF = vecs[i].of;
      #1;
      check(vecs[i].name, actual(), vecs[i].exp);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
